program_loader: RTL

Boot-time loader sitting directly upstream of the multicycle CPU's memory bank. It accepts a byte stream (header, program words, checksum) over a valid/ready handshake and writes the assembled 16-bit words into memory through the bank's external write port. It holds the CPU in reset until the image is written and verified. On success it asserts `cpu_run`; on a size or checksum fault it latches `error` and keeps the CPU halted.

---
 rtl/loader_pkg.sv | 22 ++
 rtl/byte_pair_assembler.sv | 24 ++
 rtl/program_loader.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/loader_pkg.sv
// Shared types and defaults for the boot-time program loader.
// State encoding plus default base address, stride and size limit.
package loader_pkg;

  typedef enum logic [3:0] {
    IDLE,
    HDR_HI,
    HDR_LO,
    DAT_HI,
    DAT_LO,
    WRITE,
    CHK_HI,
    CHK_LO,
    DONE,
    ERROR
  } state_e;

  localparam logic [15:0] DEF_BASE_ADDR = 16'h0000;
  localparam logic [15:0] DEF_ADDR_STEP = 16'd2;
  localparam logic [15:0] DEF_MAX_WORDS = 16'd1024;

endpackage

// File: rtl/byte_pair_assembler.sv
// Holds a captured high byte and pairs it with the live low byte.
// Ports: clock, reset (async low), take_hi, byte_in -> word.
module byte_pair_assembler (
  input  logic        clock,
  input  logic        reset,
  input  logic        take_hi,
  input  logic [7:0]  byte_in,
  output logic [15:0] word
);

  logic [7:0] hi_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hi_q <= '0;
    end else if (take_hi) begin
      hi_q <= byte_in;
    end
  end

  // Low byte is taken straight from the stream on its consume edge.
  assign word = {hi_q, byte_in};

endmodule

// File: rtl/program_loader.sv
// Boot loader: byte stream -> 16-bit memory writes, then releases CPU.
// Ports: stream in (valid/ready), bank write port, run/busy/done/error.
import loader_pkg::*;

module program_loader #(
  parameter logic [15:0] BASE_ADDR = DEF_BASE_ADDR,
  parameter logic [15:0] ADDR_STEP = DEF_ADDR_STEP,
  parameter logic [15:0] MAX_WORDS = DEF_MAX_WORDS
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        load_start,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_write,
  output logic        mem_read,
  output logic        cpu_run,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] words_loaded
);

  state_e      state_q;
  state_e      state_d;
  logic        take;
  logic        take_hi;
  logic        start;
  logic [15:0] word;
  logic [15:0] count_q;
  logic [15:0] sum_q;
  logic [15:0] wl_inc;
  logic [15:0] addr_now;

  byte_pair_assembler u_asm (
    .clock   (clock),
    .reset   (reset),
    .take_hi (take_hi),
    .byte_in (in_data),
    .word    (word)
  );

  assign mem_read = 1'b0;
  assign take     = in_valid && in_ready;
  assign wl_inc   = words_loaded + 16'd1;
  assign addr_now = BASE_ADDR + 16'(words_loaded * ADDR_STEP);

  always_comb begin
    in_ready = 1'b0;
    unique case (state_q)
      HDR_HI, HDR_LO,
      DAT_HI, DAT_LO,
      CHK_HI, CHK_LO: in_ready = 1'b1;
      default:        in_ready = 1'b0;
    endcase
  end

  assign take_hi = take && (state_q inside {HDR_HI, DAT_HI, CHK_HI});

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    unique case (state_q)
      IDLE, DONE, ERROR: begin
        if (load_start) begin
          state_d = HDR_HI;
          start   = 1'b1;
        end
      end
      HDR_HI: if (take) state_d = HDR_LO;
      HDR_LO: begin
        if (take) begin
          if (word > MAX_WORDS)   state_d = ERROR;
          else if (word == '0)    state_d = CHK_HI;
          else                    state_d = DAT_HI;
        end
      end
      DAT_HI: if (take) state_d = DAT_LO;
      DAT_LO: if (take) state_d = WRITE;
      // WRITE is a fixed single cycle, no byte consumed.
      WRITE: begin
        if (wl_inc == count_q) state_d = CHK_HI;
        else                   state_d = DAT_HI;
      end
      CHK_HI: if (take) state_d = CHK_LO;
      CHK_LO: begin
        if (take) begin
          if (word == sum_q) state_d = DONE;
          else               state_d = ERROR;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      count_q      <= '0;
      sum_q        <= '0;
      words_loaded <= '0;
      mem_addr     <= BASE_ADDR;
      mem_wdata    <= '0;
      mem_write    <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      cpu_run      <= 1'b0;
    end else begin
      state_q   <= state_d;
      // Strobe is registered so it lines up with the WRITE cycle.
      mem_write <= (state_d == WRITE);
      busy      <= !(state_d inside {IDLE, DONE, ERROR});
      if (start) begin
        words_loaded <= '0;
        sum_q        <= '0;
        done         <= 1'b0;
        error        <= 1'b0;
        cpu_run      <= 1'b0;
      end
      if (state_q == HDR_LO && take) begin
        count_q <= word;
      end
      if (state_q == DAT_LO && take) begin
        mem_addr  <= addr_now;
        mem_wdata <= word;
      end
      if (state_q == WRITE) begin
        words_loaded <= wl_inc;
        sum_q        <= sum_q + mem_wdata;
      end
      if (state_q == CHK_LO && state_d == DONE) begin
        done    <= 1'b1;
        cpu_run <= 1'b1;
      end
      if (state_d == ERROR && state_q != ERROR) begin
        error <= 1'b1;
      end
    end
  end

endmodule
